// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared FPU types: operand formats, one-hot op indices,
//               rounding-mode / sub-op encoding, exception flags and the
//               EMPTY/FULL pipeline-stage state used by the schedulers.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

  typedef enum logic [1:0] {
    FP32 = 2'd0,
    FP64 = 2'd1,
    FP16 = 2'd2,
    BF16 = 2'd3
  } fp_format_e;

  // Storage width of one operand in the given format
  function automatic int flen_bits(input fp_format_e fmt);
    case (fmt)
      FP64:       return 64;
      FP16, BF16: return 16;
      default:    return 32;
    endcase
  endfunction

  // Index width for a requester count, never narrower than one bit
  function automatic int id_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One-hot operation vector bit positions
  localparam int FPU_OP_NUM     = 4;
  localparam int FPU_OP_FCMP    = 0;  // rm: RNE=LE, RTZ=LT, RDN=EQ
  localparam int FPU_OP_FMINMAX = 1;  // rm: RNE=MIN, RTZ=MAX
  localparam int FPU_OP_FCLASS  = 2;
  localparam int FPU_OP_FSGNJ   = 3;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    DYN = 3'b111
  } roundmode_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  // Occupancy of a single-entry pipeline register
  typedef enum logic {
    STG_EMPTY = 1'b0,
    STG_FULL  = 1'b1
  } stage_e;

endpackage
`default_nettype wire

// File: rtl/fpu_utils_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : fpu_utils_rr_arb
// Description : Round-robin arbiter. Grants the first requester at or after
//               the pointer (wrapping), only while enabled; the pointer then
//               moves one past the winner.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_utils_rr_arb
  import fpu_pkg::*;
#(
  parameter  int N     = 2,
  localparam int IDX_W = id_bits(N)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N-1:0]     i_req,
  input  logic             i_en,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W:0]   w_cand;
  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  // Priority search starting at the pointer, wrapping past N-1 back to 0
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_cand >= (IDX_W+1)'(N)) begin
        w_cand = w_cand - (IDX_W+1)'(N);
      end
      if (!w_found && i_req[w_cand[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_idx   = w_cand[IDX_W-1:0];
      end
    end
  end

  // One-hot grant, suppressed entirely when the consumer cannot take it
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = w_idx;
    if (w_found && i_en) begin
      o_gnt[w_idx] = 1'b1;
    end
  end

  // Pointer advances past the winner only on an actual grant
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (w_found && i_en) begin
      r_ptr <= (w_idx == IDX_W'(N-1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpu_fcmp_sched.sv
`default_nettype none
// ============================================================================
// Module      : fpu_fcmp_sched
// Description : Shares one fpu_fcmp unit between NUM_REQ requesters. A
//               round-robin grant loads the issue register, which drives the
//               unit; its result is captured with the requester ID in the
//               response register. One op per cycle, lossless backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_fcmp_sched
  import fpu_pkg::*;
#(
  parameter  fp_format_e FP_FMT  = FP32,
  parameter  int         NUM_REQ = 2,
  localparam int         FLEN    = flen_bits(FP_FMT),
  localparam int         ID_W    = id_bits(NUM_REQ)
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst,
  input  logic [NUM_REQ-1:0]                         i_req_valid,
  output logic [NUM_REQ-1:0]                         o_req_ready,
  input  logic [NUM_REQ-1:0][1:0][FLEN-1:0]          i_req_rs,
  input  logic [NUM_REQ-1:0][FPU_OP_NUM-1:0]         i_req_op,
  input  logic [NUM_REQ-1:0][$bits(roundmode_e)-1:0] i_req_rm,
  output logic                                       o_fcmp_valid,
  input  logic                                       i_fcmp_ready,
  output logic [2:0][FLEN-1:0]                       o_fcmp_rs,
  output logic [FPU_OP_NUM-1:0]                      o_fcmp_op,
  output roundmode_e                                 o_fcmp_rm,
  input  logic                                       i_fcmp_valid,
  input  logic [FLEN-1:0]                            i_fcmp_result,
  input  fflags_t                                    i_fcmp_fflags,
  output logic                                       o_fcmp_out_ready,
  output logic                                       o_rsp_valid,
  output logic [ID_W-1:0]                            o_rsp_id,
  output logic [FLEN-1:0]                            o_rsp_result,
  output fflags_t                                    o_rsp_fflags,
  input  logic                                       i_rsp_ready
);

  typedef logic [ID_W-1:0] sched_id_t;

  stage_e                r_iss_state, w_iss_next;
  stage_e                r_rsp_state, w_rsp_next;
  sched_id_t             r_iss_id;
  logic [FLEN-1:0]       r_iss_rs1, r_iss_rs2;
  logic [FPU_OP_NUM-1:0] r_iss_op;
  roundmode_e            r_iss_rm;
  sched_id_t             r_rsp_id;
  logic [FLEN-1:0]       r_rsp_result;
  fflags_t               r_rsp_fflags;

  logic                  w_iss_vld, w_rsp_vld;
  logic                  w_rsp_fire, w_rsp_free, w_iss_fire, w_iss_free;
  logic [NUM_REQ-1:0]    w_gnt;
  sched_id_t             w_gnt_idx;
  logic                  w_gnt_any;

  assign w_iss_vld  = (r_iss_state == STG_FULL);
  assign w_rsp_vld  = (r_rsp_state == STG_FULL);
  assign w_rsp_fire = w_rsp_vld & i_rsp_ready;
  assign w_rsp_free = ~w_rsp_vld | w_rsp_fire;
  // The unit hands over a result only when the response slot can absorb it
  assign w_iss_fire = w_iss_vld & i_fcmp_ready & i_fcmp_valid & w_rsp_free;
  assign w_iss_free = ~w_iss_vld | w_iss_fire;
  assign w_gnt_any  = |w_gnt;

  fpu_utils_rr_arb #(.N(NUM_REQ)) u_arb (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req     (i_req_valid),
    .i_en      (w_iss_free),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  // Stage occupancy registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_iss_state <= STG_EMPTY;
      r_rsp_state <= STG_EMPTY;
    end else begin
      r_iss_state <= w_iss_next;
      r_rsp_state <= w_rsp_next;
    end
  end

  // Next occupancy: a new load wins over a drain in the same cycle
  always_comb begin
    w_iss_next = r_iss_state;
    w_rsp_next = r_rsp_state;
    if (w_gnt_any) begin
      w_iss_next = STG_FULL;
    end else if (w_iss_fire) begin
      w_iss_next = STG_EMPTY;
    end
    if (w_iss_fire) begin
      w_rsp_next = STG_FULL;
    end else if (w_rsp_fire) begin
      w_rsp_next = STG_EMPTY;
    end
  end

  // Issue payload: captured from the granted requester, held until issued
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_iss_id  <= '0;
      r_iss_rs1 <= '0;
      r_iss_rs2 <= '0;
      r_iss_op  <= '0;
      r_iss_rm  <= RNE;
    end else if (w_gnt_any) begin
      r_iss_id  <= w_gnt_idx;
      r_iss_rs1 <= i_req_rs[w_gnt_idx][0];
      r_iss_rs2 <= i_req_rs[w_gnt_idx][1];
      r_iss_op  <= i_req_op[w_gnt_idx];
      r_iss_rm  <= roundmode_e'(i_req_rm[w_gnt_idx]);
    end
  end

  // Response payload: unit result tagged with the issuing requester
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_rsp_fflags <= '0;
    end else if (w_iss_fire) begin
      r_rsp_id     <= r_iss_id;
      r_rsp_result <= i_fcmp_result;
      r_rsp_fflags <= i_fcmp_fflags;
    end
  end

  assign o_req_ready      = w_gnt;
  assign o_fcmp_valid     = w_iss_vld;
  assign o_fcmp_rs        = {{FLEN{1'b0}}, r_iss_rs2, r_iss_rs1};
  assign o_fcmp_op        = r_iss_op;
  assign o_fcmp_rm        = r_iss_rm;
  assign o_fcmp_out_ready = w_rsp_free;
  assign o_rsp_valid      = w_rsp_vld;
  assign o_rsp_id         = r_rsp_id;
  assign o_rsp_result     = r_rsp_result;
  assign o_rsp_fflags     = r_rsp_fflags;

endmodule
`default_nettype wire
